fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the pipelined MIPS core. Owns the fetch PC, issues one instruction-memory read at a time, and presents `pc`/`inst`/`inst_valid` to the IF/ID capture register, which samples them on the falling edge of `clk` and is held by `stop`. Branch, jump, exception and eret redirects resolved downstream arrive as a single `redirect` pulse with a target and flush everything fetched on the wrong path.

## Interface

- `RESET_PC`, 32'h0040_0000, first fetch address after reset.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stop`  in  1  downstream stall. Output is held while `inst_valid`=1 and `stop`=1.
- `redirect`  in  1  one-cycle flush-and-redirect request.
- `redirect_target`  in  32  new fetch address. Bits [1:0] are forced to 0.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  32  read address, word aligned.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid. Exactly one per accepted request, no earlier than the cycle after acceptance.
- `imem_rdata`  in  32  read data.
- `pc`  out  32  address of `inst`.
- `inst`  out  32  fetched instruction. 32'h0 (nop) when invalidated.
- `inst_valid`  out  1  `pc`/`inst` hold a live instruction.

## Operation

- Registers:
  - `fetch_pc` (32)
  - output register `pc`/`inst`/`inst_valid`
  - one-entry skid buffer `sk_pc`/`sk_inst`/`sk_valid`
  - `kill` flag
  - state
- States and transitions:
  - IDLE: entered on reset. Unconditionally goes to REQ after one cycle.
  - REQ: `imem_req`=1, `imem_addr`=`fetch_pc`. Goes to WAIT when `imem_ready`=1.
  - WAIT: waits for `imem_rvalid`.
  - FULL: response parked in the skid buffer. No requests are issued.
- `imem_req` is decoded from state only (state==REQ). It never depends on `stop`.
- Output is consumed on any cycle where `inst_valid`=1 and `stop`=0. Output may load when `!inst_valid || !stop`.
- `imem_rvalid` in WAIT with `kill`=0:
  - If the output may load: load `pc`←`fetch_pc`, `inst`←`imem_rdata`, `inst_valid`←1. Then `fetch_pc`←`fetch_pc`+4 and go to REQ.
  - Otherwise: load the skid buffer with the same values, `fetch_pc`+=4, go to FULL.
- `imem_rvalid` in WAIT with `kill`=1: data is discarded, `kill`←0, go to REQ.
- FULL, when the output may load: skid moves to the output, `sk_valid`←0, go to REQ.
- `redirect`=1 has priority over everything else in that cycle:
  - `fetch_pc`←{`redirect_target`[31:2],2'b00}.
  - `inst_valid`←0, `inst`←0, `sk_valid`←0. `pc` is unchanged.
  - Next state and `kill`:
    - From IDLE, FULL or REQ without handshake: go to REQ.
    - From REQ with `imem_ready`=1 the same cycle: the request is in flight. Go to WAIT with `kill`←1.
    - From WAIT without `imem_rvalid`: stay in WAIT with `kill`←1.
    - From WAIT with `imem_rvalid` the same cycle: data is discarded, go to REQ with `kill`←0.
- `fetch_pc`+4 wraps modulo 2^32. 32'hFFFF_FFFC is followed by 32'h0000_0000.

## Timing

- Reset values:
  - state IDLE, `fetch_pc`=RESET_PC, `kill`=0, `sk_valid`=0
  - `pc`=RESET_PC, `inst`=0, `inst_valid`=0
  - `imem_req`=0, `imem_addr`=RESET_PC
- Reset asserted mid-transaction drops all state immediately. Any late `imem_rvalid` arriving while in IDLE is ignored.
- First `imem_req` appears in the second cycle after `rst_n` rises.
- Memory with zero wait states (`imem_ready`=1, `rvalid` the next cycle) gives 2 cycles per instruction:
  - cycle N: REQ accepted
  - cycle N+1: WAIT with rvalid
  - edge ending N+1: `inst_valid`=1, and the next REQ starts
- All outputs change on the rising edge. The IF/ID register samples them on the falling edge, so they are stable for half a cycle.
- At most one request is outstanding. The skid buffer guarantees no response is lost when `stop` rises while a request is in flight.

## Test plan

- **Reset and sequential fetch.** Release reset with a 1-cycle-latency memory returning addr^32'hA5A5_0000 → `inst_valid` sequence shows `pc` 0x0040_0000, 0x0040_0004, 0x0040_0008, each with matching `inst`, and each valid one cycle out of every two.
- **Stall with in-flight request.** Assert `stop` for 5 cycles while `inst_valid`=1 and a request is outstanding → the response goes to the skid buffer, state is FULL, and no `imem_req` is issued. `pc` holds. When `stop` falls, the next `pc`+4 is presented with no skipped or duplicated address.
- **Redirect in WAIT with 3-cycle memory latency.** `redirect_target`=0x0040_0103 → the stale rvalid is dropped, the next `imem_addr`=0x0040_0100, and the first valid `pc` is 0x0040_0100.
- **Redirect coinciding with `imem_ready` handshake** → the in-flight response is discarded via `kill`, and the following request address is the target.
- **Redirect while `stop`=1 and the skid buffer is full** → `inst_valid` falls to 0 and `inst`=0 the next cycle, the skid buffer is emptied, and fetch resumes at the target.
- **Wrap-around and mid-flight reset.** Redirect to 0xFFFF_FFFC → `imem_addr` goes 0xFFFF_FFFC, then 0x0000_0000. Asserting `rst_n`=0 during WAIT → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem read in flight and
// presents pc/inst/inst_valid to the IF/ID register, with a one-entry skid for stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stop,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] sk_pc;
  logic [31:0] sk_inst;
  logic        sk_valid;
  logic        kill;

  logic        may_load;
  logic        accept;
  logic [31:0] next_pc;

  assign may_load  = !inst_valid || !stop;
  assign accept    = (state == REQ) && imem_ready;
  assign next_pc   = fetch_pc + 32'd4;

  assign imem_req  = (state == REQ);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      kill       <= 1'b0;
      sk_valid   <= 1'b0;
      sk_pc      <= RESET_PC;
      sk_inst    <= 32'h0;
      pc         <= RESET_PC;
      inst       <= 32'h0;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      // A flush wins over everything; an already-accepted read must still drain.
      fetch_pc   <= {redirect_target[31:2], 2'b00};
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      sk_valid   <= 1'b0;
      case (state)
        REQ: begin
          state <= accept ? WAIT : REQ;
          kill  <= accept;
        end
        WAIT: begin
          if (imem_rvalid) begin
            state <= REQ;
            kill  <= 1'b0;
          end else begin
            state <= WAIT;
            kill  <= 1'b1;
          end
        end
        default: begin
          state <= REQ;
          kill  <= 1'b0;
        end
      endcase
    end else begin
      if (inst_valid && !stop)
        inst_valid <= 1'b0;
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready)
            state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              fetch_pc <= next_pc;
              if (may_load) begin
                pc         <= fetch_pc;
                inst       <= imem_rdata;
                inst_valid <= 1'b1;
                state      <= REQ;
              end else begin
                // Downstream is stalled: park the response so it is not lost.
                sk_pc    <= fetch_pc;
                sk_inst  <= imem_rdata;
                sk_valid <= 1'b1;
                state    <= FULL;
              end
            end
          end
        end
        FULL: begin
          if (may_load) begin
            pc         <= sk_pc;
            inst       <= sk_inst;
            inst_valid <= sk_valid;
            sk_valid   <= 1'b0;
            state      <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed cycle table, a mid-flight reset sequence and a
// randomized run checked against a transaction-level stream model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        stop;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stop(stop), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst), .inst_valid(inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stop;
    logic        redir;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        ci;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic rd, input logic rv, input logic [31:0] d,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic ci, input logic [31:0] ei);
    vec_t v;
    v.stop = s; v.redir = r; v.tgt = t; v.rdy = rd; v.rv = rv; v.rdata = d;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_pc = ep; v.ci = ci; v.e_inst = ei;
    return v;
  endfunction

  // random-phase model state
  logic        busy;
  int          cnt;
  int          consumed;
  logic [31:0] mem_addr;
  logic [31:0] exp_acc;
  logic [31:0] exp_pc;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;
  logic        prev_redir;
  logic        prev_hold;

  initial begin
    rst_n = 1'b0; stop = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    //         stop redir tgt           rdy rv rdata          | req addr          vld pc            ci inst
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_0000, 0, 32'h0040_0000, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_0000, 0, 32'h0040_0000, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'hA5E5_0000,  0, 32'h0040_0000, 0, 32'h0040_0000, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_0004, 1, 32'h0040_0000, 1, 32'hA5E5_0000));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'hA5E5_0004,  0, 32'h0040_0004, 0, 32'h0040_0000, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_0008, 1, 32'h0040_0004, 1, 32'hA5E5_0004));
    tbl.push_back(mk(1, 0, 32'h0,          1, 1, 32'hA5E5_0008,  0, 32'h0040_0008, 1, 32'h0040_0004, 1, 32'hA5E5_0004));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_000C, 1, 32'h0040_0004, 1, 32'hA5E5_0004));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_000C, 1, 32'h0040_0004, 1, 32'hA5E5_0004));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_000C, 1, 32'h0040_0004, 1, 32'hA5E5_0004));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_000C, 1, 32'h0040_0004, 1, 32'hA5E5_0004));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_000C, 1, 32'h0040_0008, 1, 32'hA5E5_0008));
    tbl.push_back(mk(0, 1, 32'h0040_0103,  1, 0, 32'h0,          0, 32'h0040_000C, 0, 32'h0040_0008, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_0100, 0, 32'h0040_0008, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'hDEAD_BEEF,  0, 32'h0040_0100, 0, 32'h0040_0008, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_0100, 0, 32'h0040_0008, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'hA5E5_0100,  0, 32'h0040_0100, 0, 32'h0040_0008, 1, 32'h0));
    tbl.push_back(mk(0, 1, 32'h0040_0200,  1, 0, 32'h0,          1, 32'h0040_0104, 1, 32'h0040_0100, 1, 32'hA5E5_0100));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'h1234_5678,  0, 32'h0040_0200, 0, 32'h0040_0100, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_0200, 0, 32'h0040_0100, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'hA5E5_0200,  0, 32'h0040_0200, 0, 32'h0040_0100, 1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0040_0204, 1, 32'h0040_0200, 1, 32'hA5E5_0200));
    tbl.push_back(mk(1, 0, 32'h0,          1, 1, 32'hA5E5_0204,  0, 32'h0040_0204, 1, 32'h0040_0200, 1, 32'hA5E5_0200));
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFF,  1, 0, 32'h0,          0, 32'h0040_0208, 1, 32'h0040_0200, 1, 32'hA5E5_0200));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0040_0200, 1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 1, 32'h5A5A_FFFC,  0, 32'hFFFF_FFFC, 0, 32'h0040_0200, 1, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 1, 32'h5A5A_FFFC));
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0000_0000, 0, 32'hFFFF_FFFC, 0, 32'h0));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("row%0d req", i),  imem_req,   tbl[i].e_req);
      chk($sformatf("row%0d addr", i), imem_addr,  tbl[i].e_addr);
      chk($sformatf("row%0d vld", i),  inst_valid, tbl[i].e_vld);
      chk($sformatf("row%0d pc", i),   pc,         tbl[i].e_pc);
      if (tbl[i].ci || tbl[i].e_vld)
        chk($sformatf("row%0d inst", i), inst, tbl[i].e_inst);
      stop            = tbl[i].stop;
      redirect        = tbl[i].redir;
      redirect_target = tbl[i].tgt;
      imem_ready      = tbl[i].rdy;
      imem_rvalid     = tbl[i].rv;
      imem_rdata      = tbl[i].rdata;
      @(negedge clk);
    end

    // Reset dropped while a read is outstanding takes effect without a clock edge.
    chk("pre_reset_req", imem_req, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req",  imem_req,   1'b0);
    chk("async_rst_addr", imem_addr,  RESET_PC);
    chk("async_rst_vld",  inst_valid, 1'b0);
    chk("async_rst_pc",   pc,         RESET_PC);
    chk("async_rst_inst", inst,       32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("late_rvalid_req",  imem_req,   1'b1);
    chk("late_rvalid_addr", imem_addr,  RESET_PC);
    chk("late_rvalid_vld",  inst_valid, 1'b0);

    // Randomized run: the delivered stream must be consecutive words from the last
    // restart point, each carrying the word stored at its own address.
    busy = 1'b0; cnt = 0; consumed = 0; mem_addr = 32'h0;
    exp_acc = RESET_PC; exp_pc = RESET_PC;
    prev_pc = 32'h0; prev_inst = 32'h0; prev_redir = 1'b0; prev_hold = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (prev_redir) begin
        chk("flush_vld",  inst_valid, 1'b0);
        chk("flush_inst", inst,       32'h0);
      end else if (prev_hold) begin
        chk("hold_vld",  inst_valid, 1'b1);
        chk("hold_pc",   pc,         prev_pc);
        chk("hold_inst", inst,       prev_inst);
      end
      chk("one_outstanding", imem_req && busy, 1'b0);

      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_addr ^ KEY;
        end
      end
      stop            = ($urandom % 3) == 0;
      redirect        = ($urandom % 20) == 0;
      redirect_target = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      imem_ready      = ($urandom % 3) != 0;

      if (imem_rvalid) busy = 1'b0;
      if (imem_req && imem_ready) begin
        chk("accept_addr", imem_addr, exp_acc);
        busy     = 1'b1;
        cnt      = $urandom_range(1, 3);
        mem_addr = imem_addr;
        exp_acc  = imem_addr + 32'd4;
      end
      if (inst_valid && !stop) begin
        chk("stream_pc",   pc,   exp_pc);
        chk("stream_inst", inst, pc ^ KEY);
        exp_pc = pc + 32'd4;
        consumed++;
      end
      if (redirect) begin
        exp_acc = {redirect_target[31:2], 2'b00};
        exp_pc  = {redirect_target[31:2], 2'b00};
      end
      prev_redir = redirect;
      prev_hold  = inst_valid && stop && !redirect;
      prev_pc    = pc;
      prev_inst  = inst;
      @(negedge clk);
    end
    chk("progress", consumed >= 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
